// File: rtl/pid_ctrl.sv
// Balance PID controller: saturated P, windowed I, rate-derived D and a soft-start ramp
// that scales the downstream balance/steer math.
module pid_ctrl #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] ptch_rt,
    input  logic               pwr_up,
    input  logic               rider_off,
    output logic signed [11:0] PID_cntrl,
    output logic        [7:0]  ss_tmr
);

    localparam logic [26:0] RAMP_STEP = FAST_SIM ? 27'd256 : 27'd1;

    logic signed [9:0]  ptch_err_sat;
    logic signed [14:0] p_term, i_term, d_term, pid_sum;
    logic signed [11:0] pid_sat;
    logic signed [17:0] integrator, integ_add, integ_sum;
    logic               integ_ovf;
    logic        [26:0] ramp;

    always_comb begin
        if (ptch > 16'sd511)
            ptch_err_sat = 10'sd511;
        else if (ptch < -16'sd512)
            ptch_err_sat = -10'sd512;
        else
            ptch_err_sat = ptch[9:0];
    end

    assign p_term  = $signed({{5{ptch_err_sat[9]}}, ptch_err_sat}) * 15'sd5;
    assign i_term  = $signed({{3{integrator[17]}}, integrator[17:6]});
    // Sign-extend before negating so a most-negative rate (-512) becomes +512.
    assign d_term  = -$signed({{5{ptch_rt[15]}}, ptch_rt[15:6]});
    assign pid_sum = p_term + i_term + d_term;

    always_comb begin
        if (pid_sum > 15'sd2047)
            pid_sat = 12'sd2047;
        else if (pid_sum < -15'sd2048)
            pid_sat = -12'sd2048;
        else
            pid_sat = pid_sum[11:0];
    end

    // Overflow only when both addends share a sign the result does not.
    assign integ_add = $signed({{8{ptch_err_sat[9]}}, ptch_err_sat});
    assign integ_sum = integrator + integ_add;
    assign integ_ovf = (integrator[17] == integ_add[17]) && (integ_sum[17] != integrator[17]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PID_cntrl  <= '0;
            integrator <= '0;
        end else begin
            if (vld)
                PID_cntrl <= pid_sat;
            if (rider_off)
                integrator <= '0;
            else if (vld && !integ_ovf)
                integrator <= integ_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ramp <= '0;
        else if (!pwr_up)
            ramp <= '0;
        else if (ramp[26:19] != 8'hFF)
            ramp <= ramp + RAMP_STEP;
    end

    assign ss_tmr = ramp[26:19];

endmodule

// File: tb/tb_pid_ctrl.sv
// Directed bench for pid_ctrl: integer reference model compared every cycle, plus
// hand-computed literal expectations at key points.
module tb_pid_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] PID_cntrl;
    logic        [7:0]  ss_tmr;

    int vectors = 0;
    int errors  = 0;

    int m_pid  = 0;
    int m_int  = 0;
    int m_ramp = 0;

    pid_ctrl #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .ptch     (ptch),
        .ptch_rt  (ptch_rt),
        .pwr_up   (pwr_up),
        .rider_off(rider_off),
        .PID_cntrl(PID_cntrl),
        .ss_tmr   (ss_tmr)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the sampled inputs.
    always @(posedge clk) begin
        int e, n, rt;
        if (!rst_n) begin
            m_pid = 0; m_int = 0; m_ramp = 0;
        end else begin
            e  = sat(int'(ptch), -512, 511);
            rt = int'(ptch_rt);
            if (vld)
                m_pid = sat(5 * e + (m_int >>> 6) - (rt >>> 6), -2048, 2047);
            if (rider_off)
                m_int = 0;
            else if (vld) begin
                n = m_int + e;
                if (n <= 131071 && n >= -131072)
                    m_int = n;
            end
            if (!pwr_up)
                m_ramp = 0;
            else if ((m_ramp >>> 19) != 255)
                m_ramp = m_ramp + 256;
        end
    end

    always @(negedge clk) begin
        check("model_pid",   int'(PID_cntrl), m_pid);
        check("model_integ", int'(dut.integrator), m_int);
        check("model_ss",    int'(ss_tmr), m_ramp >>> 19);
    end

    task automatic pulse(input logic signed [15:0] p, input logic signed [15:0] rt, input logic ro);
        @(negedge clk);
        vld = 1'b1; ptch = p; ptch_rt = rt; rider_off = ro;
        @(negedge clk);
        vld = 1'b0; rider_off = 1'b0;
        #1;
    endtask

    task automatic clear_integ();
        @(negedge clk);
        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0;
        #1;
        check("integ_clear", int'(dut.integrator), 0);
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b1; ptch = 16'sh0100; ptch_rt = '0;
        pwr_up = 1'b1; rider_off = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_pid",   int'(PID_cntrl), 0);
        check("rst_ss",    int'(ss_tmr), 0);
        check("rst_integ", int'(dut.integrator), 0);

        @(negedge clk);
        rst_n = 1'b1; vld = 1'b0; pwr_up = 1'b0;

        pulse(16'sh0100, 16'sh0000, 1'b0);
        check("p_path_pid",   int'(PID_cntrl), 1280);
        check("p_path_integ", int'(dut.integrator), 256);
        clear_integ();
        check("hold_pid", int'(PID_cntrl), 1280);

        pulse(16'sh4000, 16'sh0000, 1'b0);
        check("sat_pos_pid", int'(PID_cntrl), 2047);
        check("sat_integ",   int'(dut.integrator), 511);
        clear_integ();

        pulse(16'sh0000, 16'sh1000, 1'b0);
        check("d_path_pid", int'(PID_cntrl), -64);

        pulse(16'shC000, 16'sh0000, 1'b0);
        check("sat_neg_pid", int'(PID_cntrl), -2048);
        clear_integ();

        // Most-negative rate maps to +512; +1 rate bit contributes nothing.
        pulse(16'sh8000, 16'sh8000, 1'b0);
        check("d_min_pid", int'(PID_cntrl), -2048 + 0);
        clear_integ();
        pulse(16'sh0000, 16'sh8000, 1'b0);
        check("d_min_only", int'(PID_cntrl), 512);

        for (int i = 0; i < 256; i++)
            pulse(16'sd511, 16'sh0000, 1'b0);
        check("integ_limit", int'(dut.integrator), 130816);
        pulse(16'sd511, 16'sh0000, 1'b0);
        check("integ_nowrap", int'(dut.integrator), 130816);
        check("integ_pid", int'(PID_cntrl), 2047);
        clear_integ();

        // rider_off wins over vld, but PID still loads.
        pulse(16'sh0100, 16'sh0000, 1'b1);
        check("ro_vld_integ", int'(dut.integrator), 0);
        check("ro_vld_pid",   int'(PID_cntrl), 1280);

        // Reset mid-accumulation and mid-ramp.
        pwr_up = 1'b1;
        pulse(16'sd100, 16'sh0000, 1'b0);
        pulse(16'sd100, 16'sh0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; pwr_up = 1'b0;
        #1;
        check("rst_mid_integ", int'(dut.integrator), 0);
        check("rst_mid_pid",   int'(PID_cntrl), 0);

        // Soft start: one ss_tmr step per 2048 clocks.
        @(negedge clk);
        pwr_up = 1'b1;
        repeat (6143) @(negedge clk);
        #1;
        check("ss_6143", int'(ss_tmr), 2);
        @(negedge clk);
        #1;
        check("ss_6144", int'(ss_tmr), 3);

        // Jump close to the top of the ramp rather than spend 500k clocks.
        #1;
        force dut.ramp = 27'h7F7FC00;
        m_ramp = 27'h7F7FC00;
        #1;
        release dut.ramp;
        repeat (3) @(negedge clk);
        #1;
        check("ss_pre_ff", int'(ss_tmr), 8'hFE);
        @(negedge clk);
        #1;
        check("ss_ff", int'(ss_tmr), 8'hFF);
        repeat (20) @(negedge clk);
        #1;
        check("ss_hold", int'(ss_tmr), 8'hFF);
        pwr_up = 1'b0;
        @(negedge clk);
        #1;
        check("ss_drop", int'(ss_tmr), 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
